top_dot_acc_4s: RTL and testbench

Sequential signed dot-product accumulator feeding the matrix-inversion datapath. It accepts a stream of LEN signed operand pairs through a valid/ready handshake and forms each product with a full-width signed multiply. It sums the products in a widened accumulator and presents one signed result per LEN-beat vector on a valid/ready output. It is the consumer stage of the small signed multiplier and performs the row×column reductions for the matrix-manipulation core.

---
 rtl/top_dot_acc_4s.sv | 123 ++++++++++++
 tb/tb_top_dot_acc_4s.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/top_dot_acc_4s.sv
// Signed LEN-term dot-product accumulator; result valid the cycle after the LEN-th beat, held until out_ready.
// Optional output saturation via macro TOP_DOT_ACC_SAT_EN (default: two's-complement wrap, out_sat tied 0).
module top_dot_acc_4s #(
    parameter int DIN_W = 4,
    parameter int LEN   = 4,
    parameter int OUT_W = 8
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic signed [DIN_W-1:0] in_a,
    input  logic signed [DIN_W-1:0] in_b,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sat,
    output logic                    busy
);
    localparam int ACC_W = 2*DIN_W + $clog2(LEN);
    localparam int CNT_W = $clog2(LEN+1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [OUT_W-1:0]   res_q, res_d;
    logic                      sat_q, sat_d;

    logic signed [2*DIN_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [OUT_W-1:0]   res_nar;
    logic                      sat_nar;
    logic                      accept;
    logic                      last_beat;

    assign prod      = in_a * in_b;
    assign acc_sum   = acc_q + ACC_W'(prod);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == CNT_W'(LEN-1));

`ifdef TOP_DOT_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        res_nar = acc_sum[OUT_W-1:0];
        sat_nar = 1'b0;
        if (acc_sum > SAT_MAX) begin
            res_nar = SAT_MAX[OUT_W-1:0];
            sat_nar = 1'b1;
        end else if (acc_sum < SAT_MIN) begin
            res_nar = SAT_MIN[OUT_W-1:0];
            sat_nar = 1'b1;
        end
    end
`else
    assign res_nar = acc_sum[OUT_W-1:0];
    assign sat_nar = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ACC;
            S_ACC:   if (accept && last_beat) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = ap_rst_n && (state_q != S_OUT);
        out_valid = (state_q == S_OUT);
        busy      = (state_q != S_IDLE);
        out_data  = res_q;
        out_sat   = sat_q;
    end

    // Result register captures the narrowed sum on the final beat and holds through backpressure.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        res_d = res_q;
        sat_d = sat_q;
        if (accept) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_beat) begin
                res_d = res_nar;
                sat_d = sat_nar;
            end
        end
        if ((state_q == S_OUT) && out_ready) begin
            acc_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
            sat_q <= sat_d;
        end
    end
endmodule

// File: tb/tb_top_dot_acc_4s.sv
// Bench for top_dot_acc_4s: directed vector table, reset/backpressure sequences, randomized vectors vs arithmetic model.
module tb_top_dot_acc_4s;
    localparam int DIN_W = 4;
    localparam int LEN   = 4;
    localparam int OUT_W = 8;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic [DIN_W-1:0] in_a = '0;
    logic [DIN_W-1:0] in_b = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_sat;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 ap_clk = ~ap_clk;

    top_dot_acc_4s #(.DIN_W(DIN_W), .LEN(LEN), .OUT_W(OUT_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    typedef struct {
        string                      name;
        logic [LEN-1:0][DIN_W-1:0]  a;
        logic [LEN-1:0][DIN_W-1:0]  b;
        int                         gap_pct;
        int                         hold;
        logic [OUT_W-1:0]           d;
        logic                       s;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: plain integer dot product, then narrowing rule.
    task automatic model(input logic [LEN-1:0][DIN_W-1:0] av, input logic [LEN-1:0][DIN_W-1:0] bv,
                         output logic [OUT_W-1:0] d, output logic s);
        int sum;
        sum = 0;
        for (int i = 0; i < LEN; i++)
            sum += int'($signed(av[i])) * int'($signed(bv[i]));
        d = sum[OUT_W-1:0];
        s = 1'b0;
`ifdef TOP_DOT_ACC_SAT_EN
        if (sum > 127) begin
            d = 8'h7F; s = 1'b1;
        end else if (sum < -128) begin
            d = 8'h80; s = 1'b1;
        end
`endif
    endtask

    task automatic run_vec(input string tag, input logic [LEN-1:0][DIN_W-1:0] av,
                           input logic [LEN-1:0][DIN_W-1:0] bv, input int gap_pct, input int hold,
                           input logic [OUT_W-1:0] exp_d, input logic exp_s);
        for (int i = 0; i < LEN; i++) begin
            if (gap_pct >= 100 || int'($urandom_range(99)) < gap_pct) begin
                @(negedge ap_clk);
                in_valid = 1'b0;
                if (i > 0) chk({tag, " busy_gap"}, 32'(busy), 32'd1);
            end
            @(negedge ap_clk);
            chk({tag, " busy_beat"}, 32'(busy), (i > 0) ? 32'd1 : 32'd0);
            chk({tag, " in_ready_beat"}, 32'(in_ready), 32'd1);
            chk({tag, " out_valid_early"}, 32'(out_valid), 32'd0);
            in_valid  = 1'b1;
            in_a      = av[i];
            in_b      = bv[i];
            out_ready = 1'($urandom);
            @(posedge ap_clk);
        end
        @(negedge ap_clk);
        chk({tag, " out_valid_latency"}, 32'(out_valid), 32'd1);
        chk({tag, " out_data"}, 32'(out_data), 32'(exp_d));
        chk({tag, " out_sat"}, 32'(out_sat), 32'(exp_s));
        chk({tag, " in_ready_out"}, 32'(in_ready), 32'd0);
        in_valid  = (hold > 0);
        in_a      = 4'($urandom);
        in_b      = 4'($urandom);
        out_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge ap_clk);
            chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold_data"}, 32'(out_data), 32'(exp_d));
            chk({tag, " hold_sat"}, 32'(out_sat), 32'(exp_s));
            chk({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
            if (h == hold - 1) out_ready = 1'b1;
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, " post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " post_busy"}, 32'(busy), 32'd0);
        chk({tag, " post_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " post_sat"}, 32'(out_sat), 32'd0);
    endtask

    initial begin
        logic [LEN-1:0][DIN_W-1:0] ra, rb;
        logic [OUT_W-1:0]          rd;
        logic                      rs;

        tbl[0] = '{"basic", {4'd4, 4'd3, 4'd2, 4'd1}, {4'd1, 4'd1, 4'd1, 4'd1}, 0, 0, 8'd10, 1'b0};
        tbl[1] = '{"backpressure", {4'd4, 4'd3, 4'd2, 4'd1}, {4'd1, 4'd1, 4'd1, 4'd1}, 0, 5, 8'd10, 1'b0};
        tbl[4] = '{"gaps", {4'h4, 4'hD, 4'h2, 4'hF}, {4'h3, 4'h3, 4'h3, 4'h3}, 100, 1, 8'd6, 1'b0};
`ifdef TOP_DOT_ACC_SAT_EN
        tbl[2] = '{"pos_ovf", {4'h8, 4'h8, 4'h8, 4'h8}, {4'h8, 4'h8, 4'h8, 4'h8}, 0, 0, 8'h7F, 1'b1};
        tbl[3] = '{"neg_ovf", {4'h8, 4'h8, 4'h8, 4'h8}, {4'h7, 4'h7, 4'h7, 4'h7}, 0, 2, 8'h80, 1'b1};
        tbl[5] = '{"sevens", {4'h7, 4'h7, 4'h7, 4'h7}, {4'h7, 4'h7, 4'h7, 4'h7}, 0, 0, 8'h7F, 1'b1};
`else
        tbl[2] = '{"pos_ovf", {4'h8, 4'h8, 4'h8, 4'h8}, {4'h8, 4'h8, 4'h8, 4'h8}, 0, 0, 8'h00, 1'b0};
        tbl[3] = '{"neg_ovf", {4'h8, 4'h8, 4'h8, 4'h8}, {4'h7, 4'h7, 4'h7, 4'h7}, 0, 2, 8'h20, 1'b0};
        tbl[5] = '{"sevens", {4'h7, 4'h7, 4'h7, 4'h7}, {4'h7, 4'h7, 4'h7, 4'h7}, 0, 0, 8'hC4, 1'b0};
`endif

        // Reset state and in_ready forced low during reset.
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst in_ready_low", 32'(in_ready), 32'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_sat", 32'(out_sat), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);

        for (int t = 0; t < 6; t++)
            run_vec(tbl[t].name, tbl[t].a, tbl[t].b, tbl[t].gap_pct, tbl[t].hold, tbl[t].d, tbl[t].s);

        // Reset mid-vector: two beats, one reset cycle, then a clean vector of ones.
        for (int i = 0; i < 2; i++) begin
            @(negedge ap_clk);
            in_valid = 1'b1; in_a = 4'd5; in_b = 4'd3;
            @(posedge ap_clk);
        end
        @(negedge ap_clk);
        chk("midrst busy_before", 32'(busy), 32'd1);
        in_valid = 1'b0;
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("midrst in_ready_low", 32'(in_ready), 32'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_data", 32'(out_data), 32'd0);
        run_vec("midrst_ones", {4'd1, 4'd1, 4'd1, 4'd1}, {4'd1, 4'd1, 4'd1, 4'd1}, 0, 0, 8'd4, 1'b0);

        // Randomized vectors with random gaps and backpressure.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < LEN; i++) begin
                ra[i] = 4'($urandom);
                rb[i] = 4'($urandom);
            end
            model(ra, rb, rd, rs);
            run_vec($sformatf("rnd%0d", r), ra, rb, 30, int'($urandom_range(3)), rd, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
